instruction_loader: RTL and testbench
=====================================

# instruction_loader

Program loader that sits directly upstream of the fetch-stage instruction memory. It assembles a byte stream from the debug UART receiver into 32-bit words and writes them sequentially into instruction memory through its write port. Loading starts at byte address 0 and stops on a HALT word or when memory is full. The pipeline must not be stepped while the loader is busy.

## Interface
Parameters:
- NB, 32, instruction/data word width in bits
- TAM, 256, instruction memory depth in words
- HALT_WORD, 32'hFFFF_FFFF, end-of-program marker; it is written to memory, then loading ends

Ports:
- i_clk  in  1  system clock; all logic on posedge
- i_reset  in  1  synchronous, active-low reset
- i_start  in  1  one-cycle pulse; begins a load
- i_rx_data  in  8  received byte
- i_rx_done  in  1  one-cycle strobe; i_rx_data is valid
- o_instruction_write_enable  out  1  one-cycle write pulse to instruction memory
- o_instruction_address  out  NB  byte address of the write, word-aligned ([1:0] = 0)
- o_instruction_data  out  NB  word to write
- o_busy  out  1  high in RECEIVE (and CHECK, if compiled in)
- o_done  out  1  high in DONE
- o_full  out  1  load ended because TAM words were written without a HALT_WORD
- o_word_count  out  $clog2(TAM)+1  words written in the current load
- o_checksum_error  out  1  only with LOADER_CHECKSUM_EN; tied 0 otherwise

## Operation
- States: IDLE, RECEIVE, CHECK (macro only), DONE.
- Reset (i_reset = 0 at posedge) forces the following, including mid-load:
  - State IDLE.
  - All outputs 0.
  - Byte index 0, word count 0, address 0, checksum 0.
  - Any partial word is discarded.
- IDLE:
  - i_start moves to RECEIVE and clears address, word count, byte index, o_full and o_checksum_error.
  - i_rx_done is ignored.
- RECEIVE:
  - Each i_rx_done shifts the byte into the assembly register, little-endian: the 1st byte becomes bits [7:0] and the 4th becomes bits [31:24].
  - Byte index counts 0..3 and wraps.
- On the 4th byte, in the next cycle:
  - o_instruction_write_enable = 1.
  - o_instruction_data = the assembled word.
  - o_instruction_address = word count × 4.
- Word count and address increment after the write.
- If the written word equals HALT_WORD, or word count reaches TAM, the FSM leaves RECEIVE (to DONE, or CHECK with the macro).
- o_full = 1 only when the TAM limit caused the exit. A HALT_WORD in slot TAM-1 exits as halt with o_full = 0.
- i_start while busy is ignored.
- DONE:
  - o_done held high; bytes ignored.
  - i_start restarts the load exactly as from IDLE.

## Timing
- Write pulse is asserted in the cycle after the posedge that samples the 4th i_rx_done. It lasts exactly 1 cycle.
- Address and data are registered and stable for the whole pulse. This satisfies the memory's negedge write.
- A byte arriving in the same cycle as a write pulse is accepted as byte 0 of the next word, so back-to-back strobes on consecutive cycles lose nothing.
- Minimum spacing is 4 cycles per word. There is no backpressure.
- Transition to DONE/CHECK occurs on the same edge that ends the final write pulse: o_busy falls and o_done rises in the cycle after the pulse.
- i_start and i_rx_done in the same cycle while in IDLE/DONE: start is taken and the byte is dropped.
- A trailing partial word (fewer than 4 bytes) is never written.

## Configuration
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of every accepted program byte is kept.
  - After the final write, the FSM enters CHECK and waits for exactly one more byte.
  - At that byte it moves to DONE. o_checksum_error = 1 if the byte does not equal the running XOR, and holds until the next start or reset.
  - o_busy stays high in CHECK.
- Undefined:
  - CHECK state and the XOR register are absent.
  - The FSM exits directly to DONE, and o_checksum_error is constant 0.

## Test plan
- Basic load: start, then bytes 13 00 00 20, EF BE AD DE, FF FF FF FF.
  - Expect write pulses at addresses 0x0, 0x4, 0x8 with data 0x2000_0013, 0xDEAD_BEEF, 0xFFFF_FFFF.
  - Then o_done = 1, o_word_count = 3, o_full = 0.
- Back-to-back: 8 consecutive-cycle rx strobes 01..08.
  - Expect 0x0403_0201 at 0x0 and 0x0807_0605 at 0x4.
  - No byte lost across a write-pulse cycle.
- Overflow with TAM = 4: 16 non-halt bytes.
  - Expect 4 writes (addresses 0x0–0xC), then o_full = 1, o_done = 1.
  - A 17th byte causes no write.
- Reset mid-word: 2 bytes, then i_reset = 0 for 1 cycle.
  - Expect all outputs 0 and state IDLE.
  - A new start plus 4 bytes writes address 0x0 with only the new bytes.
- Restart and ignore cases:
  - i_start while busy changes nothing.
  - i_start in DONE clears the count, and the next word writes address 0x0.
- Checksum (macro defined): bytes 01 02 03 04 FF FF FF FF.
  - Checksum byte 0x04 gives o_checksum_error = 0.
  - Rerun with 0x05: o_checksum_error = 1.

Source files
------------

// File: rtl/instruction_loader.sv
// instruction_loader: packs debug-UART bytes (little-endian) into words and writes them sequentially into instruction memory.
// Build option LOADER_CHECKSUM_EN adds a trailing XOR checksum byte, checked in the CHECK state.
module instruction_loader #(
    parameter int unsigned   NB        = 32,
    parameter int unsigned   TAM       = 256,
    parameter logic [NB-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [7:0]             i_rx_data,
    input  logic                   i_rx_done,
    output logic                   o_instruction_write_enable,
    output logic [NB-1:0]          o_instruction_address,
    output logic [NB-1:0]          o_instruction_data,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_full,
    output logic [$clog2(TAM):0]   o_word_count,
    output logic                   o_checksum_error
);

    // state   | meaning
    // IDLE    | waiting for a start pulse
    // RECEIVE | assembling bytes and writing words
    // CHECK   | waiting for the checksum byte (LOADER_CHECKSUM_EN only)
    // DONE    | load finished; start pulse reloads from address 0

    localparam int unsigned CW = $clog2(TAM) + 1;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RECEIVE = 2'd1, DONE = 2'd2, CHECK = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RECEIVE = 2'd1, DONE = 2'd2} state_t;
`endif

    state_t          state;
    state_t          state_next;
    logic [1:0]      byte_idx;
    logic [23:0]     partial;
    logic [CW-1:0]   word_count;
    logic [NB-1:0]   address;
    logic [NB-1:0]   data;
    logic            write_enable;
    logic            full;
    logic            start_load;
    logic            at_limit;
    logic            last_write;

    assign start_load = i_start && (state == IDLE || state == DONE);
    assign at_limit   = (word_count == CW'(TAM - 1));
    assign last_write = write_enable && ((data == HALT_WORD) || at_limit);

    always_ff @(posedge i_clk) begin
        if (!i_reset) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_start) state_next = RECEIVE;
`ifdef LOADER_CHECKSUM_EN
            RECEIVE: if (last_write) state_next = CHECK;
            CHECK:   if (i_rx_done) state_next = DONE;
`else
            RECEIVE: if (last_write) state_next = DONE;
`endif
            DONE:    if (i_start) state_next = RECEIVE;
            default: state_next = IDLE;
        endcase
    end

    // The write pulse cycle also accepts byte 0 of the next word, so counters advance in parallel with byte capture.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            byte_idx     <= '0;
            partial      <= '0;
            word_count   <= '0;
            address      <= '0;
            data         <= '0;
            write_enable <= 1'b0;
            full         <= 1'b0;
        end else begin
            write_enable <= 1'b0;
            if (start_load) begin
                byte_idx   <= '0;
                partial    <= '0;
                word_count <= '0;
                address    <= '0;
                full       <= 1'b0;
            end else if (state == RECEIVE) begin
                if (write_enable) begin
                    word_count <= word_count + CW'(1);
                    address    <= address + NB'(4);
                    if (at_limit && data != HALT_WORD) full <= 1'b1;
                end
                if (i_rx_done) begin
                    byte_idx <= byte_idx + 2'd1;
                    case (byte_idx)
                        2'd0:    partial[7:0]   <= i_rx_data;
                        2'd1:    partial[15:8]  <= i_rx_data;
                        2'd2:    partial[23:16] <= i_rx_data;
                        default: begin
                            write_enable <= 1'b1;
                            data         <= {i_rx_data, partial};
                        end
                    endcase
                end
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] checksum;
    logic       checksum_error;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            checksum       <= '0;
            checksum_error <= 1'b0;
        end else if (start_load) begin
            checksum       <= '0;
            checksum_error <= 1'b0;
        end else if (state == RECEIVE && i_rx_done) begin
            checksum <= checksum ^ i_rx_data;
        end else if (state == CHECK && i_rx_done) begin
            checksum_error <= (i_rx_data != checksum);
        end
    end

    assign o_checksum_error = checksum_error;
    assign o_busy           = (state == RECEIVE) || (state == CHECK);
`else
    assign o_checksum_error = 1'b0;
    assign o_busy           = (state == RECEIVE);
`endif

    assign o_done                     = (state == DONE);
    assign o_full                     = full;
    assign o_word_count               = word_count;
    assign o_instruction_write_enable = write_enable;
    assign o_instruction_address      = address;
    assign o_instruction_data         = data;

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: word vectors from tables, write pulses checked against an expected-write scoreboard.
module tb_instruction_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        start4 = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done = 1'b0;

    logic        we, busy, done, full, cserr;
    logic [31:0] addr, data;
    logic [8:0]  wc;
    logic        we4, busy4, done4, full4, cserr4;
    logic [31:0] addr4, data4;
    logic [2:0]  wc4;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    instruction_loader dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_rx_data(rx_data), .i_rx_done(rx_done),
        .o_instruction_write_enable(we), .o_instruction_address(addr), .o_instruction_data(data),
        .o_busy(busy), .o_done(done), .o_full(full), .o_word_count(wc), .o_checksum_error(cserr)
    );

    instruction_loader #(.TAM(4)) dut4 (
        .i_clk(clk), .i_reset(reset), .i_start(start4), .i_rx_data(rx_data), .i_rx_done(rx_done),
        .o_instruction_write_enable(we4), .o_instruction_address(addr4), .o_instruction_data(data4),
        .o_busy(busy4), .o_done(done4), .o_full(full4), .o_word_count(wc4), .o_checksum_error(cserr4)
    );

    typedef struct packed {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  b3;
        logic [31:0] word;
    } vec_t;

    logic [63:0] q[$];
    logic [63:0] q4[$];
    logic [31:0] exp_addr = 0;
    logic [31:0] exp_addr4 = 0;
    logic [7:0]  run_xor = 0;
    logic        prev_we = 0;
    logic        prev_we4 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Scoreboard side: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        logic [63:0] e;
        if (we) begin
            check("we_single", prev_we, 0);
            check("write_expected", 64'(q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("wr_addr", addr, e[63:32]);
                check("wr_data", data, e[31:0]);
            end
        end
        if (we4) begin
            check("we4_single", prev_we4, 0);
            check("write4_expected", 64'(q4.size() != 0), 1);
            if (q4.size() != 0) begin
                e = q4.pop_front();
                check("wr4_addr", addr4, e[63:32]);
                check("wr4_data", data4, e[31:0]);
            end
        end
        prev_we  = we;
        prev_we4 = we4;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
        idle(gap);
    endtask

    task automatic send_word(input vec_t v, input int gap, input bit to4);
        if (to4) begin
            q4.push_back({exp_addr4, v.word});
            exp_addr4 += 4;
        end else begin
            q.push_back({exp_addr, v.word});
            exp_addr += 4;
        end
        run_xor ^= v.b0 ^ v.b1 ^ v.b2 ^ v.b3;
        send_byte(v.b0, gap);
        send_byte(v.b1, gap);
        send_byte(v.b2, gap);
        send_byte(v.b3, 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_addr = 0;
        run_xor = 0;
    endtask

    task automatic do_start4();
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        exp_addr4 = 0;
        run_xor = 0;
    endtask

    task automatic finish_check();
`ifdef LOADER_CHECKSUM_EN
        send_byte(run_xor, 1);
`endif
        idle(1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"}, we, 0);
        check({tag, "_addr"}, addr, 0);
        check({tag, "_data"}, data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_full"}, full, 0);
        check({tag, "_wc"}, wc, 0);
        check({tag, "_cserr"}, cserr, 0);
    endtask

    initial begin
        vec_t basic[3];
        vec_t b2b[2];
        vec_t halt;
        vec_t v;
        logic exp_busy_after;

        basic[0] = '{8'h13, 8'h00, 8'h00, 8'h20, 32'h2000_0013};
        basic[1] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 32'hDEAD_BEEF};
        basic[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFF_FFFF};
        b2b[0]   = '{8'h01, 8'h02, 8'h03, 8'h04, 32'h0403_0201};
        b2b[1]   = '{8'h05, 8'h06, 8'h07, 8'h08, 32'h0807_0605};
        halt     = basic[2];
`ifdef LOADER_CHECKSUM_EN
        exp_busy_after = 1'b1;
`else
        exp_busy_after = 1'b0;
`endif

        idle(3);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("reset");
        check("reset_wc4", wc4, 0);
        idle(1);

        // Basic load; the final word is handled by hand to see pulse-to-done timing.
        do_start();
        for (int i = 0; i < 2; i++) begin
            send_word(basic[i], 1, 0);
            idle(1);
        end
        send_word(basic[2], 0, 0);
        @(negedge clk);
        check("halt_pulse_we", we, 1);
        check("halt_pulse_busy", busy, 1);
        check("halt_pulse_done", done, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("after_pulse_we", we, 0);
        check("after_pulse_busy", busy, exp_busy_after);
        check("after_pulse_done", done, !exp_busy_after);
        @(posedge clk); #1;
        finish_check();
        @(negedge clk);
        check("basic_done", done, 1);
        check("basic_busy", busy, 0);
        check("basic_wc", wc, 3);
        check("basic_full", full, 0);
        check("basic_cserr", cserr, 0);
        check("basic_all_written", q.size(), 0);

        // Back-to-back strobes, restart from DONE, and a start while busy.
        @(posedge clk); #1;
        do_start();
        for (int i = 0; i < 2; i++) send_word(b2b[i], 0, 0);
        idle(1);
        @(negedge clk);
        check("b2b_wc", wc, 2);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("busy_start_wc", wc, 2);
        check("busy_start_busy", busy, 1);
        @(posedge clk); #1;
        send_word(halt, 1, 0);
        idle(1);
        finish_check();
        @(negedge clk);
        check("b2b_done", done, 1);
        check("b2b_wc_final", wc, 3);
        check("b2b_all_written", q.size(), 0);

        // Start and byte together in DONE: the byte must be dropped.
        @(posedge clk); #1;
        start = 1'b1;
        rx_done = 1'b1;
        rx_data = 8'hAA;
        @(posedge clk); #1;
        start = 1'b0;
        rx_done = 1'b0;
        exp_addr = 0;
        run_xor = 0;
        v = '{8'h11, 8'h22, 8'h33, 8'h44, 32'h4433_2211};
        send_word(v, 1, 0);
        idle(1);
        @(negedge clk);
        check("drop_wc", wc, 1);

        // Reset in the middle of a word.
        @(posedge clk); #1;
        send_byte(8'h99, 1);
        send_byte(8'h98, 1);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("midreset");
        @(posedge clk); #1;
        do_start();
        v = '{8'h55, 8'h66, 8'h77, 8'h88, 32'h8877_6655};
        send_word(v, 1, 0);
        idle(1);
        send_word(halt, 1, 0);
        idle(1);
        finish_check();
        @(negedge clk);
        check("midreset_done", done, 1);
        check("midreset_wc", wc, 2);
        check("midreset_all_written", q.size(), 0);

        // Overflow with TAM = 4, then a stray byte that must not write.
        @(posedge clk); #1;
        do_start4();
        for (int i = 0; i < 4; i++) begin
            v.b0 = 8'(16 + 4 * i);
            v.b1 = 8'(17 + 4 * i);
            v.b2 = 8'(18 + 4 * i);
            v.b3 = 8'(19 + 4 * i);
            v.word = {v.b3, v.b2, v.b1, v.b0};
            send_word(v, 1, 1);
            idle(1);
        end
        finish_check();
        @(negedge clk);
        check("ovf_full", full4, 1);
        check("ovf_done", done4, 1);
        check("ovf_busy", busy4, 0);
        check("ovf_wc", wc4, 4);
        check("ovf_all_written", q4.size(), 0);
        @(posedge clk); #1;
        send_byte(8'h5A, 2);
        @(negedge clk);
        check("ovf_extra_wc", wc4, 4);

        // HALT word in the last slot ends as halt, not full.
        @(posedge clk); #1;
        do_start4();
        @(negedge clk);
        check("restart4_full_cleared", full4, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            v.b0 = 8'(64 + i);
            v.b1 = 8'h00;
            v.b2 = 8'h00;
            v.b3 = 8'h00;
            v.word = {24'h0, v.b0};
            send_word(v, 1, 1);
            idle(1);
        end
        send_word(halt, 1, 1);
        idle(1);
        finish_check();
        @(negedge clk);
        check("lastslot_full", full4, 0);
        check("lastslot_done", done4, 1);
        check("lastslot_wc", wc4, 4);
        check("lastslot_all_written", q4.size(), 0);

`ifdef LOADER_CHECKSUM_EN
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            do_start();
            send_word(b2b[0], 1, 0);
            idle(1);
            send_word(halt, 1, 0);
            idle(2);
            @(negedge clk);
            check("cs_busy_in_check", busy, 1);
            @(posedge clk); #1;
            send_byte((k == 0) ? 8'h04 : 8'h05, 1);
            @(negedge clk);
            check("cs_done", done, 1);
            check("cs_error", cserr, (k == 0) ? 0 : 1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
